// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch vs. data load/store sharing one memory port,
// with starvation control for fetches and a wait-timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_rd_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t          r_state;
  logic [SC_W-1:0] r_starveCnt;
  logic [WC_W-1:0] r_waitCnt;

  logic w_grantD;
  logic w_timeout;

  // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
  assign w_grantD  = d_req && (!i_req || (r_starveCnt < SC_W'(STARVE_MAX)));
  assign w_timeout = !mem_ready && (r_waitCnt == WC_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_starveCnt <= '0;
      r_waitCnt   <= '0;
      mem_req     <= 1'b0;
      busy        <= 1'b0;
      mem_rd_wr   <= 1'b1;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_grantD) begin
            r_state   <= D_BUSY;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_rd_wr <= d_rd_wr;
            r_waitCnt <= '0;
            if (i_req && (r_starveCnt < SC_W'(STARVE_MAX)))
              r_starveCnt <= r_starveCnt + 1'b1;
          end else if (i_req) begin
            r_state     <= I_BUSY;
            mem_req     <= 1'b1;
            busy        <= 1'b1;
            mem_addr    <= i_addr;
            mem_wdata   <= '0;
            mem_rd_wr   <= 1'b1;
            r_waitCnt   <= '0;
            r_starveCnt <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          // A timeout completes like a normal transfer but returns all ones and latches the error.
          if (mem_ready || w_timeout) begin
            r_state   <= IDLE;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            mem_rd_wr <= 1'b1;
            mem_wdata <= '0;
            if (r_state == I_BUSY) begin
              i_done  <= 1'b1;
              i_rdata <= mem_ready ? mem_rdata : '1;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= !mem_ready ? '1 : (mem_rd_wr ? mem_rdata : '0);
            end
            if (!mem_ready)
              timeout_err <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 3, giving the maximum consecutive data grants allowed while the instruction request waits.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles to wait for mem_ready before aborting.
REQ-005 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request; level, held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word; valid only while i_done=1.
- i_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; level, held until d_done.
- d_rd_wr  in  1  1=read (load), 0=write (store).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid only while d_done=1.
- d_done  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory access active.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rd_wr  out  1  1=read, 0=write.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- busy  out  1  high in any non-IDLE state.
- timeout_err  out  1  sticky abort flag.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, I_BUSY and D_BUSY.
REQ-007 In IDLE, arbitration SHALL work as follows:
- d_req=1 and (i_req=0 or starve_cnt<STARVE_MAX) -> D_BUSY.
- otherwise i_req=1 -> I_BUSY.
- otherwise stay in IDLE.
REQ-008 On the grant edge, the block SHALL capture the winner's address, and for data also d_wdata and d_rd_wr, into holding registers; mem_* outputs SHALL drive only these registers.
REQ-009 mem_req SHALL be 1 exactly in I_BUSY and D_BUSY, starting the cycle after the request is first seen in IDLE.
REQ-010 In I_BUSY, mem_rd_wr SHALL be 1; in IDLE, mem_rd_wr SHALL be 1, mem_wdata SHALL be 0, and mem_addr SHALL hold its last value.
REQ-011 In a busy state with mem_ready=1, the next cycle SHALL be IDLE, and the matching done SHALL be 1 for that single IDLE cycle.
REQ-012 During that done cycle, the matching rdata SHALL equal mem_rdata registered at the mem_ready edge; for writes, d_rdata SHALL be 0.
REQ-013 Minimum latency from request to done SHALL be 2 cycles with zero-wait memory: grant edge, then mem_ready edge.
REQ-014 A new grant SHALL be allowed in the same IDLE cycle that done is high; a requester that still holds req during its done cycle is treated as a new request.
REQ-015 starve_cnt SHALL increment on each D_BUSY grant made while i_req=1, saturating at STARVE_MAX.
REQ-016 starve_cnt SHALL clear on every I_BUSY grant and SHALL be unchanged otherwise.
REQ-017 Dropping a req mid-transfer SHALL NOT abort the transfer; done SHALL still pulse.
REQ-018 A wait counter SHALL clear on entry to a busy state and increment each busy cycle with mem_ready=0.
REQ-019 When the wait counter reaches TIMEOUT, the block SHALL abort:
- return to IDLE.
- pulse the matching done with rdata = all ones.
- set timeout_err, which stays 1 until reset.
REQ-020 i_done and d_done SHALL never be 1 in the same cycle.
REQ-021 mem_ready while in IDLE SHALL be ignored.

Reset
REQ-022 While reset=0, the block SHALL immediately, asynchronously and regardless of state, force:
- FSM to IDLE.
- starve_cnt and wait counter to 0.
- mem_req, i_done, d_done, busy and timeout_err to 0.
- mem_rd_wr to 1.
- mem_addr, mem_wdata, i_rdata and d_rdata to 0.
REQ-023 A transfer interrupted by reset SHALL be dropped without any done pulse; after reset release, arbitration SHALL resume from IDLE on the first rising edge.

Verification
REQ-024 Fetch: i_req=1, i_addr=0x80020000, mem_ready=1 one cycle after mem_req, mem_rdata=0x27BDFFF8 -> i_done for one cycle with i_rdata=0x27BDFFF8, mem_rd_wr=1 throughout.
REQ-025 Store: d_req=1, d_rd_wr=0, d_addr=0x8011FFF8, d_wdata=0x12345678 -> mem_rd_wr=0, mem_addr/mem_wdata match the inputs, d_done pulses, d_rdata=0.
REQ-026 Contention: i_req and d_req both held high continuously -> grant order D,D,D,I,D,D,D,I (STARVE_MAX=3), never two dones in the same cycle.
REQ-027 Timeout: d_req=1 with mem_ready held 0 -> d_done after 15 busy cycles, d_rdata=0xFFFFFFFF, timeout_err=1 until reset.
REQ-028 Reset mid-transfer: reset=0 asserted in I_BUSY -> mem_req=0 with no i_done pulse; after release with i_req=1 -> fresh grant completes normally.
